data_mem_responder: RTL

//  Responder end of the M-stage data-memory interface driven by the pipelined datapath.

---
 rtl/data_mem_responder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder for the M stage: takes one load/store at a time, waits LAT
// cycles, then completes the access against a byte-writable word array.
module data_mem_responder #(
  parameter int ADDR_W = 10,
  parameter int LAT    = 2
) (
  input  logic        clka,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        mem_addr_err,
  output logic [1:0]  dbg_state
);

  if (LAT < 1) begin : g_lat_check
    $error("data_mem_responder: LAT must be >= 1");
  end

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [3:0]          wen_q, wen_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                do_write;
  logic                misaligned_now;
  logic [ADDR_W-1:0]   idx;
  logic                unused_addr_bits;

  logic [31:0] mem_array [2**ADDR_W];

  // Upper address bits are dropped on purpose: the array aliases across them.
  assign unused_addr_bits = ^mem_addr[31:ADDR_W+2];
  assign idx = addr_q[ADDR_W+1:2];

  function automatic logic is_misaligned(input logic [3:0] wen, input logic [1:0] a);
    case (wen)
      4'h0, 4'hF:             return (a != 2'b00);
      4'h3, 4'hC:             return a[0];
      4'h1, 4'h2, 4'h4, 4'h8: return 1'b0;
      default:                return 1'b1;
    endcase
  endfunction

  assign misaligned_now = is_misaligned(wen_q, addr_q[1:0]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    do_write = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_en) begin
          addr_d  = mem_addr[ADDR_W+1:0];
          wen_d   = mem_wen;
          wdata_d = mem_wdata;
          cnt_d   = CNT_W'(LAT - 1);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_DONE;
          err_d   = misaligned_now;
          if (misaligned_now) begin
            rdata_d = '0;
          end else if (wen_q == 4'h0) begin
            rdata_d = mem_array[idx];
          end else begin
            rdata_d  = '0;
            do_write = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wen_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // A reset landing on the completing cycle drops the store.
  always_ff @(posedge clka) begin
    if (do_write && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (wen_q[i]) mem_array[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign mem_stall    = ((state_q == S_IDLE) && mem_en) || (state_q == S_BUSY);
  assign mem_rdata    = rdata_q;
  assign mem_addr_err = err_q;
  assign dbg_state    = state_q;

endmodule
